load_store_unit: RTL and testbench

- Initiator side of the core's data-memory interface: accepts one load/store request at a time from the execute stage and drives the word-addressed data memory port (WriteEn, ReadEn, Addr, WriteData, ReadData).
- Handles byte, halfword and word accesses. Loads are sign- or zero-extended. Sub-word stores use a read-modify-write (RMW) sequence.
- Misaligned, out-of-range and illegal accesses are flagged as errors and never touch memory.

---
 rtl/load_store_unit.sv | 205 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Initiator side of the core's data-memory interface. Takes one load/store
//   request at a time, checks it, and drives a word-addressed memory port with
//   combinational read data. Sub-word stores are performed as a read followed
//   by a full-word write of the merged data. Loads return sign- or
//   zero-extended lane data.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/ready     request handshake (ready only while idle)
//   req_we              1 = store, 0 = load
//   req_funct3          000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr            byte address
//   req_wdata           store data (low byte/half used for sub-word stores)
//   resp_valid          one-cycle completion pulse
//   resp_rdata          extended load data (0 for stores and errors), held
//   resp_err            error flag, meaningful only with resp_valid
//   mem_WriteEn/ReadEn  memory strobes, never both high
//   mem_Addr            word index = zero-extended req_addr[ADDR_W-1:2]
//   mem_WriteData       full word to write
//   mem_ReadData        combinational read data
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_WriteEn,
  output logic              mem_ReadEn,
  output logic [31:0]       mem_Addr,
  output logic [31:0]       mem_WriteData,
  input  logic [31:0]       mem_ReadData
);

  typedef enum logic [1:0] {IDLE, LOAD, RMW_RD, ST_WR} state_t;

  localparam logic [ADDR_W-1:0] MEM_WORDS_A = ADDR_W'(MEM_WORDS);

  state_t              state_reg, state_next;
  logic                we_reg, we_next;
  logic [2:0]          funct3_reg, funct3_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [31:0]         wdata_reg, wdata_next;
  logic [31:0]         merge_reg, merge_next;
  logic                resp_valid_reg, resp_valid_next;
  logic                resp_err_reg, resp_err_next;
  logic [31:0]         resp_rdata_reg, resp_rdata_next;

  logic                req_err;
  logic                range_err;
  logic [31:0]         shifted;
  logic [31:0]         load_ext;
  logic [31:0]         rmw_word;
  logic                sub_is_half;

  // Request legality, evaluated straight from the request inputs so an
  // error is decided on the accept edge without ever touching memory.
  assign range_err = {2'b00, req_addr[ADDR_W-1:2]} >= MEM_WORDS_A;

  always_comb begin
    req_err = 1'b0;
    case (req_funct3)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = req_addr[0];
      3'b010:  req_err = (req_addr[1:0] != 2'b00);
      3'b100:  req_err = req_we;
      3'b101:  req_err = req_we | req_addr[0];
      default: req_err = 1'b1;
    endcase
    req_err = req_err | range_err;
  end

  // Accesses are aligned by construction, so shifting the word down by the
  // byte offset places both byte and half lanes at bit 0.
  assign shifted = mem_ReadData >> {addr_reg[1:0], 3'b000};

  always_comb begin
    load_ext = shifted;
    case (funct3_reg)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'h0, shifted[7:0]};
      3'b101:  load_ext = {16'h0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // Read-modify-write merge: each byte lane takes store data if it is
  // covered by the access, else keeps the word just read.
  assign sub_is_half = funct3_reg[0];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic hit;
      logic [7:0] src;
      assign hit = sub_is_half ? (addr_reg[1] == LANE[1]) : (addr_reg[1:0] == LANE);
      assign src = (sub_is_half && LANE[0]) ? wdata_reg[15:8] : wdata_reg[7:0];
      assign rmw_word[8*gi +: 8] = hit ? src : mem_ReadData[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    we_next         = we_reg;
    funct3_next     = funct3_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    merge_next      = merge_reg;
    resp_valid_next = 1'b0;
    resp_err_next   = 1'b0;
    resp_rdata_next = resp_rdata_reg;
    mem_ReadEn      = 1'b0;
    mem_WriteEn     = 1'b0;
    mem_WriteData   = 32'h0;

    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          we_next     = req_we;
          funct3_next = req_funct3;
          addr_next   = req_addr;
          wdata_next  = req_wdata;
          if (req_err) begin
            resp_valid_next = 1'b1;
            resp_err_next   = 1'b1;
            resp_rdata_next = 32'h0;
          end else if (!req_we) begin
            state_next = LOAD;
          end else if (req_funct3 == 3'b010) begin
            state_next = ST_WR;
          end else begin
            state_next = RMW_RD;
          end
        end
      end
      LOAD: begin
        mem_ReadEn      = 1'b1;
        resp_valid_next = 1'b1;
        resp_rdata_next = load_ext;
        state_next      = IDLE;
      end
      RMW_RD: begin
        mem_ReadEn = 1'b1;
        merge_next = rmw_word;
        state_next = ST_WR;
      end
      ST_WR: begin
        mem_WriteEn     = 1'b1;
        mem_WriteData   = (funct3_reg == 3'b010) ? wdata_reg : merge_reg;
        resp_valid_next = 1'b1;
        resp_rdata_next = 32'h0;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      we_reg         <= 1'b0;
      funct3_reg     <= 3'b000;
      addr_reg       <= '0;
      wdata_reg      <= 32'h0;
      merge_reg      <= 32'h0;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= 32'h0;
    end else begin
      state_reg      <= state_next;
      we_reg         <= we_next;
      funct3_reg     <= funct3_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      merge_reg      <= merge_next;
      resp_valid_reg <= resp_valid_next;
      resp_err_reg   <= resp_err_next;
      resp_rdata_reg <= resp_rdata_next;
    end
  end

  assign req_ready  = (state_reg == IDLE);
  assign resp_valid = resp_valid_reg;
  assign resp_err   = resp_err_reg;
  assign resp_rdata = resp_rdata_reg;
  assign mem_Addr   = 32'(addr_reg[ADDR_W-1:2]);

  // we_reg is latched with the request for completeness; the path taken is
  // already encoded in the state, so it does not feed any output.
  logic unused_ok;
  assign unused_ok = we_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//   Scoreboard bench: the driver pushes the expected response (error flag,
//   read data and arrival cycle) when it issues a request; an independent
//   monitor pops and compares on every resp_valid pulse. A 1024-word memory
//   model with combinational read sits on the memory port.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_WriteEn;
  logic        mem_ReadEn;
  logic [31:0] mem_Addr;
  logic [31:0] mem_WriteData;
  logic [31:0] mem_ReadData;

  load_store_unit #(.ADDR_W(32), .MEM_WORDS(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_WriteEn(mem_WriteEn), .mem_ReadEn(mem_ReadEn), .mem_Addr(mem_Addr),
    .mem_WriteData(mem_WriteData), .mem_ReadData(mem_ReadData)
  );

  always #5 clk = ~clk;

  // Memory model with a backdoor write port for preloading.
  logic [31:0] mem [0:1023];
  logic        bd_we = 1'b0;
  logic [9:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;

  assign mem_ReadData = (mem_ReadEn && mem_Addr < 32'd1024) ? mem[mem_Addr[9:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_WriteEn && mem_Addr < 32'd1024) mem[mem_Addr[9:0]] <= mem_WriteData;
    if (bd_we) mem[bd_addr] <= bd_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int en_cnt = 0;
  int resp_n = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  // Monitor: compares every response against the head of the scoreboard.
  always @(negedge clk) begin
    if (mem_ReadEn || mem_WriteEn) en_cnt++;
    chk("rd_wr_exclusive", {31'h0, mem_ReadEn & mem_WriteEn}, 32'h0);
    if (rst_n && resp_valid) begin
      resp_n++;
      $display("resp %0d: err=%0b rdata=%08h cyc=%0d", resp_n, resp_err, resp_rdata, cyc);
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp actual=1 required=0");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic poke(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Present a request, wait (bounded) for req_ready, record the expected
  // response. Returns on the negedge after the accept edge, req_valid still high.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic push, input logic e_err,
                       input logic [31:0] e_rd, input int lat);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout actual=0 required=1");
    end else begin
      $display("req: we=%0b f3=%03b addr=%08h wdata=%08h", we, f3, addr, wd);
      if (push) begin
        exp_t e;
        e.err = e_err; e.rdata = e_rd; e.cyc = cyc + lat;
        sbq.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_req();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'h0);
  endtask

  int snap_en;

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_en", {30'h0, mem_ReadEn, mem_WriteEn}, 32'h0);
    chk("rst_mem_addr", mem_Addr, 32'h0);
    chk("rst_mem_wdata", mem_WriteData, 32'h0);
    rst_n = 1'b1;

    // Word round trip
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 2);
    idle_req(); drain();
    chk("sw_mem4", mem[4], 32'hDEADBEEF);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 2);
    idle_req(); drain();

    // Sub-word read-modify-write
    poke(10'd4, 32'h11223344);
    issue(1'b1, 3'b000, 32'h12, 32'h123456AA, 1'b1, 1'b0, 32'h0, 3);
    idle_req(); drain();
    chk("sb_mem4", mem[4], 32'h11AA3344);
    issue(1'b1, 3'b001, 32'h10, 32'hFFFFBEEF, 1'b1, 1'b0, 32'h0, 3);
    idle_req(); drain();
    chk("sh_mem4", mem[4], 32'h11AABEEF);
    issue(1'b1, 3'b001, 32'h12, 32'h00005A6B, 1'b1, 1'b0, 32'h0, 3);
    idle_req(); drain();
    chk("sh_hi_mem4", mem[4], 32'h5A6BBEEF);

    // Extension
    poke(10'd4, 32'h80FF7F01);
    issue(1'b0, 3'b000, 32'h13, 32'h0, 1'b1, 1'b0, 32'hFFFFFF80, 2);
    issue(1'b0, 3'b100, 32'h13, 32'h0, 1'b1, 1'b0, 32'h00000080, 2);
    issue(1'b0, 3'b001, 32'h12, 32'h0, 1'b1, 1'b0, 32'hFFFF80FF, 2);
    issue(1'b0, 3'b101, 32'h10, 32'h0, 1'b1, 1'b0, 32'h00007F01, 2);
    issue(1'b0, 3'b000, 32'h10, 32'h0, 1'b1, 1'b0, 32'h00000001, 2);
    issue(1'b0, 3'b000, 32'h11, 32'h0, 1'b1, 1'b0, 32'h0000007F, 2);
    idle_req(); drain();

    // Errors: no memory activity, 1-cycle latency, rdata 0
    snap_en = en_cnt;
    issue(1'b0, 3'b010, 32'h11, 32'h0, 1'b1, 1'b1, 32'h0, 1);
    issue(1'b1, 3'b001, 32'h13, 32'hFFFF, 1'b1, 1'b1, 32'h0, 1);
    issue(1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 1'b1, 32'h0, 1);
    issue(1'b1, 3'b000, 32'h1000, 32'hAA, 1'b1, 1'b1, 32'h0, 1);
    issue(1'b1, 3'b100, 32'h10, 32'hAA, 1'b1, 1'b1, 32'h0, 1);
    issue(1'b0, 3'b111, 32'h10, 32'h0, 1'b1, 1'b1, 32'h0, 1);
    idle_req(); drain();
    chk("err_no_mem_access", 32'(en_cnt - snap_en), 32'h0);
    chk("err_mem4_unchanged", mem[4], 32'h80FF7F01);

    // Highest legal word index
    poke(10'd1023, 32'hCAFEF00D);
    issue(1'b0, 3'b010, 32'hFFC, 32'h0, 1'b1, 1'b0, 32'hCAFEF00D, 2);
    idle_req(); drain();

    // Back-to-back with req_valid held high
    poke(10'd0, 32'h01020304);
    poke(10'd1, 32'hA5A5A5A5);
    issue(1'b0, 3'b010, 32'h0, 32'h0, 1'b1, 1'b0, 32'h01020304, 2);
    issue(1'b0, 3'b010, 32'h4, 32'h0, 1'b1, 1'b0, 32'hA5A5A5A5, 2);
    issue(1'b1, 3'b010, 32'h8, 32'h55AA55AA, 1'b1, 1'b0, 32'h0, 2);
    idle_req(); drain();
    chk("b2b_mem2", mem[2], 32'h55AA55AA);

    // Reset during RMW_RD
    poke(10'd8, 32'h12345678);
    issue(1'b1, 3'b000, 32'h20, 32'hAA, 1'b0, 1'b0, 32'h0, 3);
    idle_req();
    chk("rmw_rd_en", {31'h0, mem_ReadEn}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_rd_en", {31'h0, mem_ReadEn}, 32'h0);
    chk("abort_wr_en", {31'h0, mem_WriteEn}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", {31'h0, req_ready}, 32'h1);
    chk("abort_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("abort_mem8", mem[8], 32'h12345678);
    issue(1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 1'b0, 32'h12345678, 2);
    idle_req(); drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
